// File: rtl/bsg_counter_set_down.sv
// Loadable down-counter: a set loads val_i, a down decrements by one.
// When set and down may coincide, the loaded value already accounts for the decrement.
module bsg_counter_set_down #(
  parameter int width_p                  = 4,
  parameter int init_val_p               = 0,
  parameter bit set_and_down_exclusive_p = 1'b0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               set_i,
  input  logic [width_p-1:0] val_i,
  input  logic               down_i,
  output logic [width_p-1:0] count_r_o
);

  logic [width_p-1:0] count_r;
  logic [width_p-1:0] count_n;

  // next-count selection
  always_comb begin
    count_n = count_r;
    if (set_i) begin
      if (set_and_down_exclusive_p) begin
        count_n = val_i;
      end else begin
        count_n = val_i - width_p'(down_i);
      end
    end else if (down_i) begin
      count_n = count_r - width_p'(1);
    end else begin
      count_n = count_r;
    end
  end

  // counter register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_r <= width_p'(init_val_p);
    end else begin
      count_r <= count_n;
    end
  end

  assign count_r_o = count_r;

endmodule

// File: rtl/bsg_wormhole_router_input_control_vc_slice.sv
// Single-VC packet framing: remaining-flit counter, latched route, sticky
// empty-dequeue error and the header/last decode seen by the output side.
module bsg_wormhole_router_input_control_vc_slice #(
  parameter int output_dirs_p      = 5,
  parameter int payload_len_bits_p = 4,
  parameter int hdr_flits_p        = 1
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          fifo_v_i,
  input  logic [output_dirs_p-1:0]      fifo_decoded_dest_i,
  input  logic [payload_len_bits_p-1:0] fifo_payload_len_i,
  input  logic                          fifo_yumi_i,
  output logic [output_dirs_p-1:0]      reqs_o,
  output logic [output_dirs_p-1:0]      route_o,
  output logic                          release_o,
  output logic                          last_o,
  output logic                          detected_header_o,
  output logic                          error_o
);

  // Largest load is a full-length body plus the extra header flits.
  localparam int max_ctr_lp    = (2**payload_len_bits_p - 1) + hdr_flits_p - 1;
  localparam int ctr_width_lp  = $clog2(max_ctr_lp + 1);
  localparam bit single_hdr_lp = (hdr_flits_p == 1);

  logic [ctr_width_lp-1:0]  ctr_r;
  logic [ctr_width_lp-1:0]  load_val_s;
  logic [output_dirs_p-1:0] route_r;
  logic                     error_r;
  logic                     idle_s;
  logic                     set_s;
  logic                     down_s;

  assign idle_s     = (ctr_r == '0);
  assign set_s      = fifo_yumi_i & idle_s;
  assign down_s     = fifo_yumi_i & ~idle_s;
  assign load_val_s = ctr_width_lp'(fifo_payload_len_i) + ctr_width_lp'(hdr_flits_p - 1);

  bsg_counter_set_down #(
    .width_p                  (ctr_width_lp),
    .init_val_p               (0),
    .set_and_down_exclusive_p (1'b1)
  ) ctr (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .set_i     (set_s),
    .val_i     (load_val_s),
    .down_i    (down_s),
    .count_r_o (ctr_r)
  );

  // route latched on every header dequeue; masked on the output while idle
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      route_r <= '0;
    end else if (set_s) begin
      route_r <= fifo_decoded_dest_i;
    end else begin
      route_r <= route_r;
    end
  end

  // sticky dequeue-while-empty flag
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      error_r <= 1'b0;
    end else begin
      error_r <= error_r | (fifo_yumi_i & ~fifo_v_i);
    end
  end

  assign release_o         = idle_s;
  assign detected_header_o = idle_s & fifo_v_i;
  assign reqs_o            = detected_header_o ? fifo_decoded_dest_i : '0;
  assign route_o           = idle_s ? '0 : route_r;
  assign error_o           = error_r;
  assign last_o            = fifo_v_i & (idle_s ? ((fifo_payload_len_i == '0) & single_hdr_lp)
                                                : (ctr_r == ctr_width_lp'(1)));

endmodule

// File: rtl/bsg_wormhole_router_input_control_vc.sv
// Per-input-port packet tracker: one independent framing slice per virtual channel.
module bsg_wormhole_router_input_control_vc #(
  parameter int output_dirs_p      = 5,
  parameter int payload_len_bits_p = 4,
  parameter int vc_num_p           = 2,
  parameter int hdr_flits_p        = 1
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [vc_num_p-1:0]                    fifo_v_i,
  input  logic [vc_num_p*output_dirs_p-1:0]      fifo_decoded_dest_i,
  input  logic [vc_num_p*payload_len_bits_p-1:0] fifo_payload_len_i,
  input  logic [vc_num_p-1:0]                    fifo_yumi_i,
  output logic [vc_num_p*output_dirs_p-1:0]      reqs_o,
  output logic [vc_num_p*output_dirs_p-1:0]      route_o,
  output logic [vc_num_p-1:0]                    release_o,
  output logic [vc_num_p-1:0]                    last_o,
  output logic [vc_num_p-1:0]                    detected_header_o,
  output logic [vc_num_p-1:0]                    error_o
);

  for (genvar v = 0; v < vc_num_p; v++) begin : vc
    bsg_wormhole_router_input_control_vc_slice #(
      .output_dirs_p      (output_dirs_p),
      .payload_len_bits_p (payload_len_bits_p),
      .hdr_flits_p        (hdr_flits_p)
    ) slice (
      .clk_i               (clk_i),
      .reset_i             (reset_i),
      .fifo_v_i            (fifo_v_i[v]),
      .fifo_decoded_dest_i (fifo_decoded_dest_i[v*output_dirs_p +: output_dirs_p]),
      .fifo_payload_len_i  (fifo_payload_len_i[v*payload_len_bits_p +: payload_len_bits_p]),
      .fifo_yumi_i         (fifo_yumi_i[v]),
      .reqs_o              (reqs_o[v*output_dirs_p +: output_dirs_p]),
      .route_o             (route_o[v*output_dirs_p +: output_dirs_p]),
      .release_o           (release_o[v]),
      .last_o              (last_o[v]),
      .detected_header_o   (detected_header_o[v]),
      .error_o             (error_o[v])
    );
  end

endmodule

// File: tb/tb_bsg_wormhole_router_input_control_vc.sv
// Bench for the wormhole input control: vector table, directed multi-cycle
// sequences and randomized traffic checked against a flit-count packet model.
module tb_bsg_wormhole_router_input_control_vc;

  localparam int HDR_A = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // two-VC instance, single-flit header
  logic [1:0] v_a, yumi_a, rel_a, last_a, det_a, err_a;
  logic [9:0] dest_a, reqs_a, route_a;
  logic [7:0] len_a;
  // one-VC instances with 3- and 4-flit headers
  logic       v_b, yumi_b, rel_b, last_b, det_b, err_b;
  logic [4:0] dest_b, reqs_b, route_b;
  logic [3:0] len_b;
  logic       v_c, yumi_c, rel_c, last_c, det_c, err_c;
  logic [4:0] dest_c, reqs_c, route_c;
  logic [3:0] len_c;

  bsg_wormhole_router_input_control_vc #(.output_dirs_p(5), .payload_len_bits_p(4), .vc_num_p(2), .hdr_flits_p(HDR_A)) dut (
    .clk_i(clk), .reset_i(reset), .fifo_v_i(v_a), .fifo_decoded_dest_i(dest_a),
    .fifo_payload_len_i(len_a), .fifo_yumi_i(yumi_a), .reqs_o(reqs_a), .route_o(route_a),
    .release_o(rel_a), .last_o(last_a), .detected_header_o(det_a), .error_o(err_a));

  bsg_wormhole_router_input_control_vc #(.output_dirs_p(5), .payload_len_bits_p(4), .vc_num_p(1), .hdr_flits_p(3)) dut_h3 (
    .clk_i(clk), .reset_i(reset), .fifo_v_i(v_b), .fifo_decoded_dest_i(dest_b),
    .fifo_payload_len_i(len_b), .fifo_yumi_i(yumi_b), .reqs_o(reqs_b), .route_o(route_b),
    .release_o(rel_b), .last_o(last_b), .detected_header_o(det_b), .error_o(err_b));

  bsg_wormhole_router_input_control_vc #(.output_dirs_p(5), .payload_len_bits_p(4), .vc_num_p(1), .hdr_flits_p(4)) dut_h4 (
    .clk_i(clk), .reset_i(reset), .fifo_v_i(v_c), .fifo_decoded_dest_i(dest_c),
    .fifo_payload_len_i(len_c), .fifo_yumi_i(yumi_c), .reqs_o(reqs_c), .route_o(route_c),
    .release_o(rel_c), .last_o(last_c), .detected_header_o(det_c), .error_o(err_c));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model for the two-VC instance: a VC is either between packets
  // or inside one with a known number of flits still to come (head included).
  bit         m_busy [2];
  int         m_left [2];
  logic [4:0] m_route[2];
  bit         m_err  [2];

  task automatic model_check();
    int         tot;
    logic [4:0] d;
    bit         hdr;
    for (int i = 0; i < 2; i++) begin
      d   = dest_a[i*5 +: 5];
      tot = int'(len_a[i*4 +: 4]) + HDR_A;
      hdr = v_a[i] && !m_busy[i];
      chk($sformatf("model det vc%0d", i), 32'(det_a[i]), 32'(hdr));
      chk($sformatf("model reqs vc%0d", i), 32'(reqs_a[i*5 +: 5]), hdr ? 32'(d) : 32'd0);
      chk($sformatf("model route vc%0d", i), 32'(route_a[i*5 +: 5]), m_busy[i] ? 32'(m_route[i]) : 32'd0);
      chk($sformatf("model release vc%0d", i), 32'(rel_a[i]), 32'(!m_busy[i]));
      chk($sformatf("model last vc%0d", i), 32'(last_a[i]),
          32'(v_a[i] && (m_busy[i] ? (m_left[i] == 1) : (tot == 1))));
      chk($sformatf("model error vc%0d", i), 32'(err_a[i]), 32'(m_err[i]));
    end
  endtask

  task automatic tick();
    int tot;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_busy[i] = 1'b0;
        m_left[i] = 0;
        m_err[i]  = 1'b0;
      end else begin
        if (yumi_a[i]) begin
          if (!m_busy[i]) begin
            tot = int'(len_a[i*4 +: 4]) + HDR_A;
            if (tot > 1) begin
              m_busy[i]  = 1'b1;
              m_left[i]  = tot - 1;
              m_route[i] = dest_a[i*5 +: 5];
            end
          end else begin
            m_left[i]--;
            if (m_left[i] == 0) m_busy[i] = 1'b0;
          end
        end
        m_err[i] = m_err[i] | (yumi_a[i] & ~v_a[i]);
      end
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic       v;
    logic [4:0] dest;
    logic [3:0] len;
    logic       yumi;
    logic [4:0] reqs;
    logic [4:0] route;
    logic       rel;
    logic       last;
    logic       det;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // VC0 of the two-VC instance: 4-flit packet to dest 00100, then a single-flit packet
    tbl[0] = '{1'b1, 5'b00100, 4'd3, 1'b0, 5'b00100, 5'b00000, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 5'b00100, 4'd3, 1'b1, 5'b00100, 5'b00000, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 5'b00010, 4'd7, 1'b1, 5'b00000, 5'b00100, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 5'b00010, 4'd7, 1'b1, 5'b00000, 5'b00100, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 5'b00010, 4'd7, 1'b1, 5'b00000, 5'b00100, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 5'b00001, 4'd0, 1'b0, 5'b00001, 5'b00000, 1'b1, 1'b1, 1'b1};
    tbl[6] = '{1'b1, 5'b00001, 4'd0, 1'b1, 5'b00001, 5'b00000, 1'b1, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 5'b00001, 4'd0, 1'b0, 5'b00000, 5'b00000, 1'b1, 1'b0, 1'b0};

    reset = 1'b1;
    v_a = '0; yumi_a = '0; dest_a = '0; len_a = '0;
    v_b = 1'b0; yumi_b = 1'b0; dest_b = '0; len_b = '0;
    v_c = 1'b0; yumi_c = 1'b0; dest_c = '0; len_c = '0;
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("reset release", 32'(rel_a), 32'd3);
    chk("reset route", 32'(route_a), 32'd0);
    chk("reset error", 32'(err_a), 32'd0);

    for (int i = 0; i < 8; i++) begin
      v_a    = {1'b0, tbl[i].v};
      dest_a = {5'b00000, tbl[i].dest};
      len_a  = {4'd0, tbl[i].len};
      yumi_a = {1'b0, tbl[i].yumi};
      #1;
      model_check();
      chk($sformatf("tbl%0d reqs", i), 32'(reqs_a[4:0]), 32'(tbl[i].reqs));
      chk($sformatf("tbl%0d route", i), 32'(route_a[4:0]), 32'(tbl[i].route));
      chk($sformatf("tbl%0d release", i), 32'(rel_a[0]), 32'(tbl[i].rel));
      chk($sformatf("tbl%0d last", i), 32'(last_a[0]), 32'(tbl[i].last));
      chk($sformatf("tbl%0d det", i), 32'(det_a[0]), 32'(tbl[i].det));
      tick();
    end

    // interleaved VCs: VC0 dest 00001 len 2, VC1 dest 10000 len 1
    v_a = 2'b11; dest_a = {5'b10000, 5'b00001}; len_a = {4'd1, 4'd2};
    yumi_a = 2'b01; #1; model_check();
    chk("il det", 32'(det_a), 32'd3);
    tick();
    yumi_a = 2'b10; #1; model_check();
    chk("il route c1", 32'(route_a), 32'({5'b00000, 5'b00001}));
    chk("il release c1", 32'(rel_a), 32'b10);
    tick();
    yumi_a = 2'b11; #1; model_check();
    chk("il route c2", 32'(route_a), 32'({5'b10000, 5'b00001}));
    chk("il last c2", 32'(last_a), 32'b10);
    chk("il release c2", 32'(rel_a), 32'b00);
    tick();
    yumi_a = 2'b01; #1; model_check();
    chk("il release c3", 32'(rel_a), 32'b10);
    chk("il route c3", 32'(route_a), 32'({5'b00000, 5'b00001}));
    chk("il last c3", 32'(last_a), 32'b01);
    tick();
    v_a = 2'b00; yumi_a = 2'b00; #1; model_check();
    chk("il release c4", 32'(rel_a), 32'd3);
    chk("il route c4", 32'(route_a), 32'd0);

    // dequeue on an empty VC1
    len_a = 8'd0; yumi_a = 2'b10; #1; model_check(); tick();
    yumi_a = 2'b00; #1; model_check();
    chk("error set", 32'(err_a), 32'b10);
    tick(); #1;
    chk("error sticky", 32'(err_a), 32'b10);

    // reset with VC0 mid-packet (counter at 3)
    v_a = 2'b01; dest_a = {5'b00000, 5'b00100}; len_a = {4'd0, 4'd3}; yumi_a = 2'b01;
    #1; model_check(); tick();
    yumi_a = 2'b00; #1; model_check();
    chk("midpkt release", 32'(rel_a[0]), 32'd0);
    chk("midpkt route", 32'(route_a[4:0]), 32'b00100);
    reset = 1'b1; tick();
    reset = 1'b0; v_a = 2'b00; #1; model_check();
    chk("post-reset release", 32'(rel_a), 32'd3);
    chk("post-reset route", 32'(route_a), 32'd0);
    chk("post-reset error", 32'(err_a), 32'd0);

    // randomized traffic on both VCs
    for (int n = 0; n < 400; n++) begin
      logic [1:0] r;
      v_a    = 2'($urandom);
      dest_a = 10'($urandom);
      len_a  = {2'b00, 2'($urandom), 2'b00, 2'($urandom)};
      if ($urandom_range(0, 7) == 0) len_a = 8'($urandom);
      r      = 2'($urandom);
      yumi_a = ($urandom_range(0, 15) != 0) ? (r & v_a) : r;
      reset  = ($urandom_range(0, 99) == 0);
      #1;
      model_check();
      tick();
    end
    reset = 1'b0; v_a = '0; yumi_a = '0;
    tick();

    // 3-flit header, len 2: five flits with a two-cycle stall after flit 2
    v_b = 1'b1; dest_b = 5'b00010; len_b = 4'd2; yumi_b = 1'b0; #1;
    chk("h3 det", 32'(det_b), 32'd1);
    chk("h3 reqs", 32'(reqs_b), 32'b00010);
    chk("h3 hdr last", 32'(last_b), 32'd0);
    for (int f = 1; f <= 5; f++) begin
      yumi_b = 1'b1;
      #1;
      chk($sformatf("h3 last f%0d", f), 32'(last_b), 32'(f == 5));
      chk($sformatf("h3 route f%0d", f), 32'(route_b), (f == 1) ? 32'd0 : 32'b00010);
      chk($sformatf("h3 release f%0d", f), 32'(rel_b), 32'(f == 1));
      tick();
      dest_b = 5'b01000; len_b = 4'd0;
      if (f == 2) begin
        yumi_b = 1'b0;
        for (int s = 0; s < 2; s++) begin
          #1;
          chk("h3 stall route", 32'(route_b), 32'b00010);
          chk("h3 stall release", 32'(rel_b), 32'd0);
          chk("h3 stall last", 32'(last_b), 32'd0);
          tick();
        end
      end
    end
    yumi_b = 1'b0; v_b = 1'b0; #1;
    chk("h3 end release", 32'(rel_b), 32'd1);
    chk("h3 end route", 32'(route_b), 32'd0);
    chk("h3 error", 32'(err_b), 32'd0);

    // longest packet: 4-flit header, len 15 -> 19 flits
    v_c = 1'b1; dest_c = 5'b10000; len_c = 4'd15;
    for (int f = 1; f <= 19; f++) begin
      yumi_c = 1'b1;
      #1;
      chk($sformatf("max last f%0d", f), 32'(last_c), 32'(f == 19));
      chk($sformatf("max release f%0d", f), 32'(rel_c), 32'(f == 1));
      chk($sformatf("max route f%0d", f), 32'(route_c), (f == 1) ? 32'd0 : 32'b10000);
      tick();
    end
    yumi_c = 1'b0; #1;
    chk("max end release", 32'(rel_c), 32'd1);
    chk("max end route", 32'(route_c), 32'd0);
    chk("max next hdr", 32'(det_c), 32'd1);
    chk("max error", 32'(err_c), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bsg_wormhole_router_input_control_vc.md
Name: bsg_wormhole_router_input_control_vc

Overview:
- Per-input-port packet tracker for a wormhole router with vc_num_p virtual channels sharing one physical input.
- Each VC has its own input FIFO head and runs an independent packet-framing counter.
- Adds multi-flit headers, a latched route for body flits, and a last-flit indication so the output side can release its lock in the same cycle as the tail.
- Also flags a sticky protocol error when a flit is dequeued from an empty FIFO.

Parameters:
- output_dirs_p, 5, number of output directions (one-hot width).
- payload_len_bits_p, 4, width of the header length field (number of body flits after the header).
- vc_num_p, 2, number of virtual channels; must be >= 1.
- hdr_flits_p, 1, flits per header; must be >= 1.

Ports:
- clk_i  input  1  clock.
- reset_i  input  1  synchronous active-high reset.
- fifo_v_i  input  vc_num_p  per-VC FIFO head valid.
- fifo_decoded_dest_i  input  vc_num_p*output_dirs_p  per-VC one-hot destination; meaningful only on the first header flit.
- fifo_payload_len_i  input  vc_num_p*payload_len_bits_p  per-VC body length; meaningful only on the first header flit.
- fifo_yumi_i  input  vc_num_p  per-VC dequeue by the output side.
- reqs_o  output  vc_num_p*output_dirs_p  header request: decoded dest when a first header flit is at the head, else 0.
- route_o  output  vc_num_p*output_dirs_p  latched one-hot dest while a packet is in flight, else 0.
- release_o  output  vc_num_p  VC idle; the next flit is a first header.
- last_o  output  vc_num_p  head flit is valid and is the final flit of its packet.
- detected_header_o  output  vc_num_p  first header flit valid at the head.
- error_o  output  vc_num_p  sticky: yumi seen while fifo_v_i low.

Behaviour:
- VC slices are fully independent; there is no cross-VC interaction in this block.
- Per VC, ctr_r counts the remaining flits of the current packet.
  - Width: ctr_width = BSG_WIDTH((2^payload_len_bits_p - 1) + hdr_flits_p - 1).
  - Arithmetic is zero-extended and cannot overflow.
- idle = (ctr_r == 0). release_o = idle.
- detected_header_o = idle & fifo_v_i.
- reqs_o = detected_header_o ? fifo_decoded_dest_i : 0.
- On yumi & idle:
  - ctr_r <= fifo_payload_len_i + hdr_flits_p - 1.
  - route_r <= fifo_decoded_dest_i.
  - If the loaded value is 0 (single-flit packet), the VC stays idle.
- On yumi & ~idle: ctr_r <= ctr_r - 1.
- Set and decrement are mutually exclusive by construction.
- route_o = idle ? 0 : route_r.
- route_r holds its value while idle, but is masked on route_o.
- last_o = fifo_v_i & (idle ? (fifo_payload_len_i == 0 && hdr_flits_p == 1) : (ctr_r == 1)).
- Combinational path: fifo_* to reqs_o, detected_header_o and last_o. All other outputs come from registers.
- Header transfer latency: route_o asserts the cycle after the header yumi.
- release_o asserts the cycle after the last flit's yumi.
- Back-to-back packets: the tail yumi is followed by the next header in the very next cycle, with no bubble.
- Error handling:
  - error_o[v] <= error_o[v] | (fifo_yumi_i[v] & ~fifo_v_i[v]).
  - Only reset clears it.
  - The counter still updates on an erroneous yumi (no masking).
- Reset values: ctr_r = 0, route_r = 0, error_o = 0.
  - Hence release_o = 1 and route_o = 0.
  - reqs_o, detected_header_o and last_o follow the inputs combinationally.
- Reset mid-packet abandons the packet.
  - The next flit at the head is treated as a header.
  - Flushing the FIFOs is the system's responsibility.
- Maximum packet: len = 2^payload_len_bits_p - 1 with hdr_flits_p = 4 loads 18 at width 4. ctr_width must hold this value.

Decomposition:
- No shared package is needed.
- ctr_width is a localparam computed inside the slice.
- One sub-module, bsg_wormhole_router_input_control_vc_slice, holds the per-VC counter, route register, error bit and output decode. The top instantiates it vc_num_p times in a generate loop.
- The counter uses bsg_counter_set_down with set_and_down_exclusive_p = 1.

Test Plan:
- Reset, single VC:
  - Inputs: fifo_v=1, dest=5'b00100, len=3, hdr_flits_p=1.
  - Required: reqs_o=00100, release_o=1, last_o=0.
  - Yumi 4 consecutive cycles. After the header, route_o=00100. last_o=1 only on the 4th flit. The cycle after, release_o=1 and route_o=0.
- Single-flit packet:
  - Inputs: len=0, hdr_flits_p=1.
  - Required: detected_header_o=1 and last_o=1 in the same cycle. After yumi, release_o stays 1 and route_o stays 0.
- Multi-flit header:
  - Inputs: hdr_flits_p=3, len=2.
  - Required: counter loads 4; total 5 flits; last_o on the 5th. Stalling yumi for 2 cycles mid-packet holds ctr_r and route_o.
- Two VCs interleaved:
  - VC0 is sent dest=00001, len=2; VC1 is sent dest=10000, len=1. Flit yumis alternate between the VCs.
  - Required: per-VC route_o is independent; each release_o asserts after its own tail. Under a simultaneous yumi on both VCs, both counters update.
- Error and reset:
  - Yumi VC1 with fifo_v=0 -> error_o=2'b10 stays set.
  - Reset mid-packet (ctr_r=3) -> release_o=1, route_o=0, error_o=0 the next cycle.
- Maximum length:
  - Inputs: len=15, hdr_flits_p=4.
  - Required: 19 flits accepted; last_o only on the 19th; no wrap-around of ctr_r.
